conv_addr_sequencer: RTL
========================

// Module: conv_addr_sequencer
// PURPOSE
//  Registered successor to the combinational window checker of the conv datapath. Walks a 1-D
//  filter window over rows held in the circular IF scratchpad, and every loaded filter over each
//  window position. Emits one (IF addr, filter addr) read beat per cycle to the MAC with a
//  valid/ready handshake. Stalls on unwritten data, releases consumed IF rows to the write side,
//  and adds programmable stride, filter count and row count.
// PARAMETERS
//  IF_ADDRESS_SIZE      8  IF scratchpad address width
//  FILTER_ADDRESS_SIZE  8  filter scratchpad address width
//  CELL_NUMS_IF         8  IF scratchpad depth (any value <= 2**IF_ADDRESS_SIZE)
//  CELL_NUMS_FILTER     8  filter scratchpad depth (any value <= 2**FILTER_ADDRESS_SIZE)
//  SIZE_W               4  width of if_size / filter_size / stride / num_filters / num_rows
// PORTS
//  clk          in   1                      clock, rising edge
//  rst          in   1                      synchronous reset, active high
//  start        in   1                      latch cfg_* and begin (ignored unless IDLE)
//  cfg_if_size  in   SIZE_W                 IF elements per row
//  cfg_filt_size in  SIZE_W                 taps per filter
//  cfg_stride   in   SIZE_W                 window step
//  cfg_num_filt in   SIZE_W                 filters stored back-to-back in filter pad
//  cfg_num_rows in   SIZE_W                 IF rows to process
//  if_avail     in   IF_ADDRESS_SIZE+1      valid IF entries counted from current row base
//  filt_avail   in   FILTER_ADDRESS_SIZE+1  valid filter entries counted from filter base 0
//  rd_ready     in   1                      MAC accepts current beat
//  rd_valid     out  1                      beat valid (can_mult)
//  if_addr      out  IF_ADDRESS_SIZE        IF read address
//  filt_addr    out  FILTER_ADDRESS_SIZE    filter read address
//  psum_last    out  1                      beat is last tap of a window/filter (par_done)
//  psum_filt    out  SIZE_W                 filter index of beat
//  psum_win     out  SIZE_W                 window index of beat
//  row_release  out  1                      1-cycle pulse: cfg_if_size IF entries freed
//  busy         out  1                      state != IDLE
//  done         out  1                      1-cycle pulse after final beat accepted
//  cfg_err      out  1                      1-cycle pulse: start with illegal config
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, row base 0, counters 0. rst mid-run aborts immediately; no
//    release/done pulse is emitted.
//  - Config legal iff: filt_size>=1, stride>=1, num_filt>=1, num_rows>=1,
//    filt_size<=if_size<=CELL_NUMS_IF, and num_filt*filt_size<=CELL_NUMS_FILTER.
//    Illegal: cfg_err next cycle, stay IDLE.
//  - Windows per row: NW = (if_size-filt_size)/stride + 1 (integer floor).
//  - Loop order, innermost first: tap k, filter f, window w, row r.
//    - if_addr   = (base + w*stride + k) mod CELL_NUMS_IF
//    - filt_addr = f*filt_size + k
//    - base starts at 0 on every start; wrap by compare-subtract, no divider.
//  - States:
//    - IDLE: legal start -> RUN.
//    - RUN: each cycle where the slot is free (!rd_valid | rd_ready), load the next beat if
//      available; otherwise drop rd_valid (stall). The beat is available iff
//      w*stride+k < if_avail AND f*filt_size+k < filt_avail.
//    - RUN: after loading the row's last beat -> RWAIT.
//    - RWAIT: on that beat's handshake, pulse row_release and set
//      base <= (base+if_size) mod CELL_NUMS_IF. If rows remain -> RUN, else pulse done -> IDLE.
//  - Latency: the first beat is valid 2 cycles after start when data is present. Sustained rate
//    is 1 beat/cycle within a row. There is exactly one bubble per row boundary, from RWAIT.
//  - Handshake: when rd_valid=1 and rd_ready=0, all beat outputs hold stable. Availability may
//    drop at any time; a loaded beat is never retracted.
//  - psum_last = (k==filt_size-1). It is registered with its beat.
//  - Simultaneous start with busy: start is ignored. cfg_* are sampled only on an accepted start.
//  - if_avail is interpreted relative to the current base. The write side subtracts if_size on
//    each row_release.
// TESTING
//  - Single-row sweep: if_size=5, filt=3, stride=1, nf=2, rows=1, avail full, ready=1.
//    Expect 18 beats, if 0,1,2 / 0,1,2 / 1,2,3 ..., filt 0,1,2 / 3,4,5 ..., 6 psum_last,
//    then row_release, then done.
//  - Stride: if_size=5, filt=3, stride=2, nf=1 -> NW=2, if addrs 0,1,2 / 2,3,4.
//  - Wrap: CELL_NUMS_IF=8, if_size=5, filt=5, rows=2 -> row1 if addrs 5,6,7,0,1; one bubble
//    between rows.
//  - Stall: if_avail=2 with filt=3 -> rd_valid=0 after beat k=1. Raise if_avail to 3 -> beat
//    k=2 (if addr 2) valid the next cycle.
//  - Backpressure: hold rd_ready=0 for 4 cycles mid-row -> outputs frozen, no beat lost or
//    duplicated.
//  - Error/reset: filt=6 > if_size=5 -> cfg_err, busy stays 0. rst asserted mid-row -> next
//    cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer: walks a 1-D filter window over circular IF scratchpad rows and every loaded
// filter, emitting one (IF addr, filter addr) read beat per cycle under a valid/ready handshake.
module conv_addr_sequencer #(
  parameter int IF_ADDRESS_SIZE     = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int CELL_NUMS_IF        = 8,
  parameter int CELL_NUMS_FILTER    = 8,
  parameter int SIZE_W              = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SIZE_W-1:0]              cfg_if_size,
  input  logic [SIZE_W-1:0]              cfg_filt_size,
  input  logic [SIZE_W-1:0]              cfg_stride,
  input  logic [SIZE_W-1:0]              cfg_num_filt,
  input  logic [SIZE_W-1:0]              cfg_num_rows,
  input  logic [IF_ADDRESS_SIZE:0]       if_avail,
  input  logic [FILTER_ADDRESS_SIZE:0]   filt_avail,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [IF_ADDRESS_SIZE-1:0]     if_addr,
  output logic [FILTER_ADDRESS_SIZE-1:0] filt_addr,
  output logic                           psum_last,
  output logic [SIZE_W-1:0]              psum_filt,
  output logic [SIZE_W-1:0]              psum_win,
  output logic                           row_release,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  // Wide enough that no offset, product or address sum below can overflow.
  localparam int CW = IF_ADDRESS_SIZE + FILTER_ADDRESS_SIZE + 2*SIZE_W + 2;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_RWAIT = 2'd2} state_t;

  localparam logic [SIZE_W-1:0] SZ_ZERO  = {SIZE_W{1'b0}};
  localparam logic [SIZE_W-1:0] SZ_ONE   = {{(SIZE_W-1){1'b0}}, 1'b1};
  localparam cnt_t              CNT_ZERO = {CW{1'b0}};

  function automatic logic cfg_legal(input logic [SIZE_W-1:0] if_sz, input logic [SIZE_W-1:0] fs,
                                     input logic [SIZE_W-1:0] st, input logic [SIZE_W-1:0] nf,
                                     input logic [SIZE_W-1:0] nr);
    logic ok;
    ok = (fs != SZ_ZERO) && (st != SZ_ZERO) && (nf != SZ_ZERO) && (nr != SZ_ZERO) &&
         (fs <= if_sz) && (cnt_t'(if_sz) <= cnt_t'(CELL_NUMS_IF)) &&
         ((cnt_t'(nf) * cnt_t'(fs)) <= cnt_t'(CELL_NUMS_FILTER));
    return ok;
  endfunction

  // Sum is always below 2*CELL_NUMS_IF, so one conditional subtract is a full modulo.
  function automatic logic [IF_ADDRESS_SIZE-1:0] wrap_if(input cnt_t sum);
    cnt_t r;
    if (sum >= cnt_t'(CELL_NUMS_IF)) begin
      r = sum - cnt_t'(CELL_NUMS_IF);
    end else begin
      r = sum;
    end
    return r[IF_ADDRESS_SIZE-1:0];
  endfunction

  state_t                         state_q, state_d;
  logic [SIZE_W-1:0]              if_size_q, if_size_d, filt_size_q, filt_size_d;
  logic [SIZE_W-1:0]              stride_q, stride_d, num_filt_q, num_filt_d;
  logic [SIZE_W-1:0]              num_rows_q, num_rows_d;
  logic [SIZE_W-1:0]              k_q, k_d, f_q, f_d, w_q, w_d, r_q, r_d;
  cnt_t                           w_off_q, w_off_d, filt_off_q, filt_off_d;
  logic [IF_ADDRESS_SIZE-1:0]     base_q, base_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [IF_ADDRESS_SIZE-1:0]     if_addr_q, if_addr_d;
  logic [FILTER_ADDRESS_SIZE-1:0] filt_addr_q, filt_addr_d;
  logic                           psum_last_q, psum_last_d;
  logic [SIZE_W-1:0]              psum_filt_q, psum_filt_d, psum_win_q, psum_win_d;
  logic                           row_release_q, row_release_d;
  logic                           busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic k_last_s, f_last_s, w_last_s, r_last_s, slot_free_s, beat_avail_s;
  cnt_t tap_off_s, ftap_s;

  assign k_last_s     = (k_q == (filt_size_q - SZ_ONE));
  assign f_last_s     = (f_q == (num_filt_q - SZ_ONE));
  assign r_last_s     = (r_q == (num_rows_q - SZ_ONE));
  // Last window once the next step would run past the row; avoids dividing to get NW.
  assign w_last_s     = ((w_off_q + cnt_t'(stride_q) + cnt_t'(filt_size_q)) > cnt_t'(if_size_q));
  assign tap_off_s    = w_off_q + cnt_t'(k_q);
  assign ftap_s       = filt_off_q + cnt_t'(k_q);
  assign beat_avail_s = (tap_off_s < cnt_t'(if_avail)) && (ftap_s < cnt_t'(filt_avail));
  assign slot_free_s  = !rd_valid_q || rd_ready;

  // Next-state, loop counters and beat generation
  always_comb begin
    state_d       = state_q;
    if_size_d     = if_size_q;
    filt_size_d   = filt_size_q;
    stride_d      = stride_q;
    num_filt_d    = num_filt_q;
    num_rows_d    = num_rows_q;
    k_d           = k_q;
    f_d           = f_q;
    w_d           = w_q;
    r_d           = r_q;
    w_off_d       = w_off_q;
    filt_off_d    = filt_off_q;
    base_d        = base_q;
    rd_valid_d    = rd_valid_q;
    if_addr_d     = if_addr_q;
    filt_addr_d   = filt_addr_q;
    psum_last_d   = psum_last_q;
    psum_filt_d   = psum_filt_q;
    psum_win_d    = psum_win_q;
    row_release_d = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        rd_valid_d = 1'b0;
        if (start) begin
          if (cfg_legal(cfg_if_size, cfg_filt_size, cfg_stride, cfg_num_filt, cfg_num_rows)) begin
            if_size_d   = cfg_if_size;
            filt_size_d = cfg_filt_size;
            stride_d    = cfg_stride;
            num_filt_d  = cfg_num_filt;
            num_rows_d  = cfg_num_rows;
            k_d         = SZ_ZERO;
            f_d         = SZ_ZERO;
            w_d         = SZ_ZERO;
            r_d         = SZ_ZERO;
            w_off_d     = CNT_ZERO;
            filt_off_d  = CNT_ZERO;
            base_d      = {IF_ADDRESS_SIZE{1'b0}};
            state_d     = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (slot_free_s) begin
          if (beat_avail_s) begin
            rd_valid_d  = 1'b1;
            if_addr_d   = wrap_if(cnt_t'(base_q) + tap_off_s);
            filt_addr_d = ftap_s[FILTER_ADDRESS_SIZE-1:0];
            psum_last_d = k_last_s;
            psum_filt_d = f_q;
            psum_win_d  = w_q;
            if (!k_last_s) begin
              k_d = k_q + SZ_ONE;
            end else begin
              k_d = SZ_ZERO;
              if (!f_last_s) begin
                f_d        = f_q + SZ_ONE;
                filt_off_d = filt_off_q + cnt_t'(filt_size_q);
              end else begin
                f_d        = SZ_ZERO;
                filt_off_d = CNT_ZERO;
                if (!w_last_s) begin
                  w_d     = w_q + SZ_ONE;
                  w_off_d = w_off_q + cnt_t'(stride_q);
                end else begin
                  w_d     = SZ_ZERO;
                  w_off_d = CNT_ZERO;
                  state_d = S_RWAIT;
                end
              end
            end
          end else begin
            rd_valid_d = 1'b0;
          end
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      S_RWAIT: begin
        if (rd_ready) begin
          rd_valid_d    = 1'b0;
          row_release_d = 1'b1;
          base_d        = wrap_if(cnt_t'(base_q) + cnt_t'(if_size_q));
          if (r_last_s) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            r_d     = r_q + SZ_ONE;
            state_d = S_RUN;
          end
        end else begin
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        rd_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register, configuration, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      if_size_q     <= SZ_ZERO;
      filt_size_q   <= SZ_ZERO;
      stride_q      <= SZ_ZERO;
      num_filt_q    <= SZ_ZERO;
      num_rows_q    <= SZ_ZERO;
      k_q           <= SZ_ZERO;
      f_q           <= SZ_ZERO;
      w_q           <= SZ_ZERO;
      r_q           <= SZ_ZERO;
      w_off_q       <= CNT_ZERO;
      filt_off_q    <= CNT_ZERO;
      base_q        <= {IF_ADDRESS_SIZE{1'b0}};
      rd_valid_q    <= 1'b0;
      if_addr_q     <= {IF_ADDRESS_SIZE{1'b0}};
      filt_addr_q   <= {FILTER_ADDRESS_SIZE{1'b0}};
      psum_last_q   <= 1'b0;
      psum_filt_q   <= SZ_ZERO;
      psum_win_q    <= SZ_ZERO;
      row_release_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      if_size_q     <= if_size_d;
      filt_size_q   <= filt_size_d;
      stride_q      <= stride_d;
      num_filt_q    <= num_filt_d;
      num_rows_q    <= num_rows_d;
      k_q           <= k_d;
      f_q           <= f_d;
      w_q           <= w_d;
      r_q           <= r_d;
      w_off_q       <= w_off_d;
      filt_off_q    <= filt_off_d;
      base_q        <= base_d;
      rd_valid_q    <= rd_valid_d;
      if_addr_q     <= if_addr_d;
      filt_addr_q   <= filt_addr_d;
      psum_last_q   <= psum_last_d;
      psum_filt_q   <= psum_filt_d;
      psum_win_q    <= psum_win_d;
      row_release_q <= row_release_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign if_addr     = if_addr_q;
  assign filt_addr   = filt_addr_q;
  assign psum_last   = psum_last_q;
  assign psum_filt   = psum_filt_q;
  assign psum_win    = psum_win_q;
  assign row_release = row_release_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule
